// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder that consumes BPC bits per clock, LSB slice first.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous active-high reset
//   start     - begin an addition; accepted in IDLE or DONE
//   A, B, Cin - operands and carry-in, sampled only on the accepting edge
//   busy      - high while the state is RUN
//   done      - one-cycle pulse while the state is DONE (results first valid)
//   Sum       - registered (A+B+Cin) mod 2^WIDTH
//   Cout      - registered carry out of bit WIDTH-1
//   overflow  - registered two's-complement overflow (carry into MSB ^ carry out of MSB)
//
// All outputs come straight from flops; there is no combinational input-to-output path.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / BPC;
  localparam int unsigned CntW = (N < 2) ? 1 : $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BPC-1:0]    slice_sum;
  logic              slice_carry;
  logic              carry_msb;
  logic [WIDTH-1:0]  acc_next;

  // One BPC-bit ripple slice. Operands are shifted right each RUN cycle, so the
  // slice always sits in the low BPC bits of a_q/b_q.
  always_comb begin
    slice_carry = carry_q;
    carry_msb   = carry_q;
    slice_sum   = '0;
    for (int i = 0; i < int'(BPC); i++) begin
      // After the loop this holds the carry into the slice's top bit, which on
      // the final slice is the carry into the word MSB.
      carry_msb    = slice_carry;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ slice_carry;
      slice_carry  = (a_q[i] & b_q[i]) | (slice_carry & (a_q[i] ^ b_q[i]));
    end
    // Slice results enter at the top and move down; after N cycles slice 0 is at bit 0.
    acc_next = (acc_q >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = StRun;
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        acc_d   = acc_next;
        carry_d = slice_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          sum_d   = acc_next;
          cout_d  = slice_carry;
          ovf_d   = carry_msb ^ slice_carry;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder in three configurations: (8,1), (4,2), (1,1).
// The driver predicts acceptance and results with plain arithmetic and queues the
// expected done cycle and result; a negedge monitor checks every output every cycle.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit fin [3];

  task automatic check(input string name, input int cfg, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h", name, cfg, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 4 : 1;
    localparam int unsigned P = (g == 1) ? 2 : 1;
    localparam int unsigned N = W / P;
    localparam int unsigned D = (N < 3) ? N : 3;

    logic         rst, start, cin, busy, done, cout, ovf;
    logic [W-1:0] a, b, sum;

    serial_adder #(.WIDTH(W), .BPC(P)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (a),
      .B       (b),
      .Cin     (cin),
      .busy    (busy),
      .done    (done),
      .Sum     (sum),
      .Cout    (cout),
      .overflow(ovf)
    );

    int           exp_cyc_q[$];
    logic [W:0]   exp_res_q[$];
    logic         exp_ovf_q[$];
    logic [W-1:0] m_sum;
    logic         m_cout, m_ovf;
    bit           has_acc, chk_en, exp_done, exp_busy;
    int           last_acc;

    // Drive one cycle of inputs; if the adder is free at the coming edge and
    // start is high, queue the arithmetic result due N cycles after that edge.
    task automatic issue(input bit st, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci);
      logic [W:0] full;
      start = st;
      a     = av;
      b     = bv;
      cin   = ci;
      if (st && (!has_acc || (cyc + 1 >= last_acc + int'(N) + 1))) begin
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        exp_cyc_q.push_back(cyc + 1 + int'(N));
        exp_res_q.push_back(full);
        exp_ovf_q.push_back((av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]));
        has_acc  = 1'b1;
        last_acc = cyc + 1;
      end
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int k);
      repeat (k) issue(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
      issue(1'b1, av, bv, ci);
      idle(int'(N));
    endtask

    task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cyc_q.delete();
      exp_res_q.delete();
      exp_ovf_q.delete();
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      has_acc = 1'b0;
    endtask

    always @(negedge clk) begin
      if (chk_en) begin
        exp_done = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        if (exp_done) begin
          {m_cout, m_sum} = exp_res_q.pop_front();
          m_ovf = exp_ovf_q.pop_front();
          void'(exp_cyc_q.pop_front());
        end
        exp_busy = has_acc && (cyc >= last_acc) && (cyc < last_acc + int'(N));
        check("done", g, 64'(done), 64'(exp_done));
        check("busy", g, 64'(busy), 64'(exp_busy));
        check("sum", g, 64'(sum), 64'(m_sum));
        check("cout", g, 64'(cout), 64'(m_cout));
        check("overflow", g, 64'(ovf), 64'(m_ovf));
      end
    end

    initial begin
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      has_acc  = 1'b0;
      last_acc = 0;
      chk_en   = 1'b0;
      m_sum    = '0;
      m_cout   = 1'b0;
      m_ovf    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      idle(2);
      // Carry-out, positive overflow, negative overflow with carry-in.
      op(W'(8'hFF), W'(8'h01), 1'b0);
      op(W'(8'h7F), W'(8'h01), 1'b0);
      op(W'(8'h80), W'(8'h80), 1'b1);
      if (2 * W + 1 <= 9) begin
        for (int x = 0; x < (1 << (2 * W + 1)); x++) begin
          op(W'(x), W'(x >> W), x[2*W]);
        end
      end
      // Random start density, operands changing every cycle.
      repeat (150) issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom));
      idle(int'(N) + 1);
      // Start held high: one result per N+1 cycles, RUN-time starts ignored.
      repeat (4 * (N + 1)) issue(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      idle(int'(N) + 1);
      // Abort mid-RUN, then a fresh addition must complete normally.
      issue(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      idle(int'(D) - 1);
      do_reset();
      idle(3);
      op(W'(8'hA5), W'(8'h3C), 1'b1);
      idle(int'(N) + 2);
      check("drain", g, 64'(exp_cyc_q.size()), 64'd0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    wait (fin[0] && fin[1] && fin[2]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
